// File: rtl/fpmul_pkg.sv
// Shared types and constant helpers for the parametrised floating-point multiplier
// and the round/pack logic it shares with the adder.
package fpmul_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic {
        RND_RNE   = 1'b0,
        RND_TRUNC = 1'b1
    } rnd_mode_e;

    // Helpers build constants at up to 64 bits; callers keep the low W bits.
    localparam int MAX_W = 64;

    function automatic int fp_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
    endfunction

    // Unsigned magnitude of infinity (all-ones exponent, zero fraction).
    function automatic logic [MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: sign 0, all-ones exponent, fraction MSB set.
    function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise / round / range-check / pack of a raw significand product.
// Handles ordinary results only; the caller overrides for special operands.
module fp_round_pack
    import fpmul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int PW    = 2 * MAN_W + 2,
    localparam int XW    = EXP_W + 2
) (
    input  logic                 i_sign,
    input  logic signed [XW-1:0] i_exp,
    input  logic [PW-1:0]        i_prod,
    input  logic                 i_trunc,
    output logic [W-1:0]         o_res,
    output logic                 o_ovf,
    output logic                 o_unf
);

    localparam logic signed [XW:0] EXP_TOP = (XW+1)'((1 << EXP_W) - 1);
    localparam logic signed [XW:0] EXP_MIN = {(XW+1){1'b0}};
    localparam logic [W-2:0]       INF_MAG = (W-1)'(fp_inf(EXP_W, MAN_W));

    logic [MAN_W-1:0]   w_frac;
    logic [MAN_W-1:0]   w_frac_r;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic               w_carry;
    logic signed [XW:0] w_exp_n;
    logic signed [XW:0] w_exp_f;

    // Normalise on the product MSB, round, then clamp to inf or zero.
    always_comb begin
        if (i_prod[PW-1]) begin
            w_frac   = i_prod[PW-2 -: MAN_W];
            w_guard  = i_prod[MAN_W];
            w_sticky = |i_prod[MAN_W-1:0];
            w_exp_n  = {i_exp[XW-1], i_exp} + (XW+1)'(1);
        end else begin
            w_frac   = i_prod[PW-3 -: MAN_W];
            w_guard  = i_prod[MAN_W-1];
            w_sticky = |i_prod[MAN_W-2:0];
            w_exp_n  = {i_exp[XW-1], i_exp};
        end
        w_inc = !i_trunc & w_guard & (w_sticky | w_frac[0]);
        {w_carry, w_frac_r} = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
        w_exp_f = w_exp_n + {{XW{1'b0}}, w_carry};
        o_ovf = 1'b0;
        o_unf = 1'b0;
        if (w_exp_f >= EXP_TOP) begin
            o_ovf = 1'b1;
            o_res = {i_sign, INF_MAG};
        end else if (w_exp_f <= EXP_MIN) begin
            o_unf = 1'b1;
            o_res = {i_sign, {(W-1){1'b0}}};
        end else begin
            o_res = {i_sign, w_exp_f[EXP_W-1:0], w_frac_r};
        end
    end

endmodule

// File: rtl/fpmul_pipe.sv
// Pipelined floating-point multiplier: operand capture, classify, multiply,
// then round/pack with IEEE special cases. A stalled output freezes every stage.
module fpmul_pipe
    import fpmul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p,
    output logic         flag_ovf,
    output logic         flag_unf,
    output logic         flag_inv
);

    localparam int           PW      = 2 * MAN_W + 2;
    localparam int           XW      = EXP_W + 2;
    localparam int           BIAS    = fp_bias(EXP_W);
    localparam logic [W-1:0] QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-2:0] INF_MAG = (W-1)'(fp_inf(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        fp_class_e c;
        if (e == {EXP_W{1'b0}}) begin
            c = CLS_ZERO;
        end else if (e == {EXP_W{1'b1}}) begin
            c = (f == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    logic w_en;

    logic            r0_valid, r0_rnd;
    logic [W-1:0]    r0_a, r0_b;

    logic               r1_valid, r1_sign;
    rnd_mode_e          r1_rnd;
    fp_class_e          r1_cls_a, r1_cls_b;
    logic [MAN_W-1:0]   r1_fa, r1_fb;
    logic signed [XW-1:0] r1_esum;

    logic               r2_valid, r2_sign;
    rnd_mode_e          r2_rnd;
    fp_class_e          r2_cls_a, r2_cls_b;
    logic [PW-1:0]      r2_prod;
    logic signed [XW-1:0] r2_esum;

    logic signed [XW-1:0] w_esum;
    logic [W-1:0]         w_rp_res, w_p;
    logic                 w_rp_ovf, w_rp_unf, w_ovf, w_unf, w_inv;

    assign w_en     = !out_valid | out_ready;
    assign in_ready = w_en;
    assign w_esum   = {2'b00, r0_a[W-2 -: EXP_W]} + {2'b00, r0_b[W-2 -: EXP_W]} - XW'(BIAS);

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
        .i_sign  (r2_sign),
        .i_exp   (r2_esum),
        .i_prod  (r2_prod),
        .i_trunc (r2_rnd == RND_TRUNC),
        .o_res   (w_rp_res),
        .o_ovf   (w_rp_ovf),
        .o_unf   (w_rp_unf)
    );

    // Special operands override the arithmetic result and suppress ovf/unf.
    always_comb begin
        w_p   = w_rp_res;
        w_ovf = w_rp_ovf;
        w_unf = w_rp_unf;
        w_inv = 1'b0;
        if (r2_cls_a == CLS_NAN || r2_cls_b == CLS_NAN ||
            (r2_cls_a == CLS_ZERO && r2_cls_b == CLS_INF) ||
            (r2_cls_a == CLS_INF && r2_cls_b == CLS_ZERO)) begin
            w_p   = QNAN;
            w_ovf = 1'b0;
            w_unf = 1'b0;
            w_inv = 1'b1;
        end else if (r2_cls_a == CLS_INF || r2_cls_b == CLS_INF) begin
            w_p   = {r2_sign, INF_MAG};
            w_ovf = 1'b0;
            w_unf = 1'b0;
        end else if (r2_cls_a == CLS_ZERO || r2_cls_b == CLS_ZERO) begin
            w_p   = {r2_sign, {(W-1){1'b0}}};
            w_ovf = 1'b0;
            w_unf = 1'b0;
        end else begin
            w_inv = 1'b0;
        end
    end

    // Whole pipe advances together on w_en; bubbles travel as cleared valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_valid  <= 1'b0;
            r0_rnd    <= 1'b0;
            r0_a      <= {W{1'b0}};
            r0_b      <= {W{1'b0}};
            r1_valid  <= 1'b0;
            r1_sign   <= 1'b0;
            r1_rnd    <= RND_RNE;
            r1_cls_a  <= CLS_ZERO;
            r1_cls_b  <= CLS_ZERO;
            r1_fa     <= {MAN_W{1'b0}};
            r1_fb     <= {MAN_W{1'b0}};
            r1_esum   <= {XW{1'b0}};
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_rnd    <= RND_RNE;
            r2_cls_a  <= CLS_ZERO;
            r2_cls_b  <= CLS_ZERO;
            r2_prod   <= {PW{1'b0}};
            r2_esum   <= {XW{1'b0}};
            out_valid <= 1'b0;
            p         <= {W{1'b0}};
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inv  <= 1'b0;
        end else if (w_en) begin
            r0_valid  <= in_valid;
            r0_rnd    <= rnd_mode;
            r0_a      <= a;
            r0_b      <= b;
            r1_valid  <= r0_valid;
            r1_sign   <= r0_a[W-1] ^ r0_b[W-1];
            r1_rnd    <= rnd_mode_e'(r0_rnd);
            r1_cls_a  <= classify(r0_a[W-2 -: EXP_W], r0_a[MAN_W-1:0]);
            r1_cls_b  <= classify(r0_b[W-2 -: EXP_W], r0_b[MAN_W-1:0]);
            r1_fa     <= r0_a[MAN_W-1:0];
            r1_fb     <= r0_b[MAN_W-1:0];
            r1_esum   <= w_esum;
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_rnd    <= r1_rnd;
            r2_cls_a  <= r1_cls_a;
            r2_cls_b  <= r1_cls_b;
            r2_prod   <= PW'({1'b1, r1_fa}) * PW'({1'b1, r1_fb});
            r2_esum   <= r1_esum;
            out_valid <= r2_valid;
            p         <= w_p;
            flag_ovf  <= w_ovf;
            flag_unf  <= w_unf;
            flag_inv  <= w_inv;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe: directed single-precision vectors, streaming
// with back-pressure, and reset with operations in flight.
module tb_fpmul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        rnd_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] p;
    logic        flag_ovf, flag_unf, flag_inv;

    typedef struct {
        logic [31:0] p;
        logic [2:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_p;
    logic [2:0]  prev_f;

    fpmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present one operand pair until accepted; expected result queued at acceptance.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic irnd,
                         input logic [31:0] ep, input logic [2:0] ef, input bit lat);
        int tries = 0;
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; rnd_mode = irnd; in_valid = 1'b1;
        #1;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, tries);
            in_valid = 1'b0;
        end else begin
            e.p = ep; e.f = ef; e.acc = cyc + 1; e.lat = lat;
            q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // Monitor: handshake rule, stall stability, and in-order scoreboard compare.
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_p", 64'(p), 64'(prev_p));
                check("hold_flags", 64'({flag_ovf, flag_unf, flag_inv}), 64'(prev_f));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got p=%h with nothing outstanding", p);
                end else begin
                    mon_e = q.pop_front();
                    check("p", 64'(p), 64'(mon_e.p));
                    check("flags{ovf,unf,inv}", 64'({flag_ovf, flag_unf, flag_inv}), 64'(mon_e.f));
                    if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'd3);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_p = p;
            prev_f = {flag_ovf, flag_unf, flag_inv};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        check("rst_flags", 64'({flag_ovf, flag_unf, flag_inv}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Directed vectors: {a, b, rnd, expected p, expected {ovf,unf,inv}}
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
        issue(32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 3'b000, 1'b1);
        issue(32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 3'b000, 1'b1);
        issue(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b001, 1'b1);
        issue(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 3'b000, 1'b1);
        issue(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 3'b000, 1'b1);
        issue(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 3'b100, 1'b1);
        issue(32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 3'b010, 1'b1);
        issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 1'b1);
        issue(32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 3'b000, 1'b1);
        issue(32'hFF800000, 32'h80000000, 1'b0, 32'h7FC00000, 3'b001, 1'b1);
        issue(32'hC0400000, 32'h40400000, 1'b1, 32'hC1100000, 3'b000, 1'b1);
        drain();

        // Streaming: 2^i * 2.0 = 2^(i+1), i.e. p = 0x40000000 + (i << 23); consumer stalls mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(32'h3F800000 + (i << 23), 32'h40000000, 1'(i % 2),
                          32'h40000000 + (i << 23), 3'b000, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight: nothing may emerge afterwards.
        issue(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b0);
        issue(32'h40400000, 32'h40000000, 1'b0, 32'h40C00000, 3'b000, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 3'b000, 1'b1);
        drain();
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
